fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline buffer.
- Owns the PC register and issues one outstanding request at a time on a ready-handshaked instruction-memory port.
- Presents instruction and PC+4 to the IF/ID buffer, together with that buffer's write enable.
- Handles hazard stalls (pc_write low), taken-branch redirects with bubble insertion, and discarding of wrong-path responses.

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID buffer.
// Owns the PC and keeps one outstanding request on a ready-handshaked
// instruction-memory port. Handles hazard stalls, branch redirects
// with bubble insertion, and discarding of wrong-path responses.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pc_write              1 = advance, 0 = hold PC and IF/ID contents
//   branch_taken/_target  one-cycle redirect request and address
//   imem_req/imem_addr    request valid and address (stable until ready)
//   imem_ready/imem_rdata response strobe and fetched word
//   inst_out/pc_out       instruction and its PC+4 for the IF/ID buffer
//   ifid_write            IF/ID buffer write enable
// Optional macro FETCH_STATS_EN adds bubble_count (32b) and
// drop_count (16b), both saturating and cleared on reset.

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        ifid_write
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] bubble_count,
   output logic [15:0] drop_count
`endif
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] pc_inc;
   logic        bubble_wr;
   logic        drop_rsp;

   assign pc_inc    = pc_q + 32'd4;
   assign imem_addr = req_addr_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      hold_inst_d = hold_inst_q;
      hold_pc_d   = hold_pc_q;
      imem_req    = 1'b0;
      inst_out    = NOP_INST;
      pc_out      = 32'd0;
      ifid_write  = 1'b0;
      bubble_wr   = 1'b0;
      drop_rsp    = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            FETCH: begin
               imem_req = 1'b1;
               if (branch_taken) begin
                  ifid_write = 1'b1;
                  bubble_wr  = 1'b1;
                  pc_d       = branch_target;
                  // An unanswered request must finish at its old address.
                  if (imem_ready) req_addr_d = branch_target;
                  else            state_d    = DROP;
               end else if (imem_ready && pc_write) begin
                  inst_out   = imem_rdata;
                  pc_out     = pc_inc;
                  ifid_write = 1'b1;
                  pc_d       = pc_inc;
                  req_addr_d = pc_inc;
               end else if (imem_ready) begin
                  hold_inst_d = imem_rdata;
                  hold_pc_d   = pc_inc;
                  state_d     = HOLD;
               end else begin
                  ifid_write = pc_write;
                  bubble_wr  = pc_write;
               end
            end
            HOLD: begin
               inst_out = hold_inst_q;
               pc_out   = hold_pc_q;
               if (branch_taken) begin
                  inst_out   = NOP_INST;
                  pc_out     = 32'd0;
                  ifid_write = 1'b1;
                  bubble_wr  = 1'b1;
                  pc_d       = branch_target;
                  req_addr_d = branch_target;
                  state_d    = FETCH;
               end else if (pc_write) begin
                  ifid_write = 1'b1;
                  pc_d       = pc_inc;
                  req_addr_d = pc_inc;
                  state_d    = FETCH;
               end
            end
            DROP: begin
               imem_req   = 1'b1;
               ifid_write = branch_taken | pc_write;
               bubble_wr  = branch_taken | pc_write;
               if (branch_taken) pc_d = branch_target;
               // The next request goes to the newest PC, even if a
               // redirect arrives together with the dropped response.
               if (imem_ready) begin
                  drop_rsp   = 1'b1;
                  req_addr_d = pc_d;
                  state_d    = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         req_addr_q  <= RESET_PC;
         hold_inst_q <= NOP_INST;
         hold_pc_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubble_count <= 32'd0;
         drop_count   <= 16'd0;
      end else begin
         if (bubble_wr && bubble_count != 32'hFFFF_FFFF)
            bubble_count <= bubble_count + 32'd1;
         if (drop_rsp && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = bubble_wr ^ drop_rsp;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random checks of fetch_unit against a
// transaction-level reference model (PC, held-word queue, drop flag).

module tb_fetch_unit;

   localparam logic [31:0] NOP0 = 32'h0000_0013;
   localparam logic [31:0] RPC0 = 32'h0000_0000;
   localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

   logic        clk;
   logic        rst_n, pc_write, branch_taken, imem_ready;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, ifid_write;
   logic [31:0] imem_addr, inst_out, pc_out;

   logic        rst1, pw1, br1, rdy1;
   logic [31:0] tgt1, rdata1;
   logic        req1, we1;
   logic [31:0] addr1, inst1, pc1;

`ifdef FETCH_STATS_EN
   logic [31:0] bubble_count, bubble_count1;
   logic [15:0] drop_count, drop_count1;
`endif

   fetch_unit #(.RESET_PC(RPC0), .NOP_INST(NOP0)) u0 (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .inst_out(inst_out), .pc_out(pc_out), .ifid_write(ifid_write)
`ifdef FETCH_STATS_EN
      , .bubble_count(bubble_count), .drop_count(drop_count)
`endif
   );

   fetch_unit #(.RESET_PC(RPC1)) u1 (
      .clk(clk), .rst_n(rst1), .pc_write(pw1),
      .branch_taken(br1), .branch_target(tgt1),
      .imem_req(req1), .imem_addr(addr1),
      .imem_ready(rdy1), .imem_rdata(rdata1),
      .inst_out(inst1), .pc_out(pc1), .ifid_write(we1)
`ifdef FETCH_STATS_EN
      , .bubble_count(bubble_count1), .drop_count(drop_count1)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc4;
   } ent_t;
   ent_t        held[$];
   logic [31:0] m_pc;
   logic        m_wrong;
   logic [31:0] m_drop_addr;
   logic [31:0] m_bub;
   logic [15:0] m_drop;

   logic        o_req, o_we;
   logic [31:0] o_addr, o_inst, o_pc;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic pw, input logic br,
                       input logic [31:0] tgt, input logic rdy);
      logic        e_req, e_we, e_bub, r;
      logic [31:0] e_addr, e_inst, e_pc, old_bub;
      logic [15:0] old_drop;
      e_req = rst && (held.size() == 0);
      r     = rdy && e_req;
      rst_n = rst;
      pc_write = pw;
      branch_taken = br;
      branch_target = tgt;
      imem_ready = r;
      #1;
      imem_rdata = r ? mem(imem_addr) : $urandom;
      e_addr = m_wrong ? m_drop_addr : m_pc;
      e_inst = NOP0;
      e_pc   = 32'd0;
      e_we   = 1'b0;
      e_bub  = 1'b0;
      old_bub  = m_bub;
      old_drop = m_drop;
      if (!rst) begin
         m_pc = RPC0;
         m_wrong = 1'b0;
         held.delete();
         m_bub = 32'd0;
         m_drop = 16'd0;
      end else if (held.size() != 0) begin
         e_inst = held[0].inst;
         e_pc   = held[0].pc4;
         if (br) begin
            e_inst = NOP0;
            e_pc = 32'd0;
            e_we = 1'b1;
            e_bub = 1'b1;
            m_pc = tgt;
            held.delete();
         end else if (pw) begin
            e_we = 1'b1;
            m_pc = m_pc + 32'd4;
            held.delete();
         end
      end else if (m_wrong) begin
         e_we = br | pw;
         e_bub = e_we;
         if (br) m_pc = tgt;
         if (r) begin
            m_wrong = 1'b0;
            if (m_drop != 16'hFFFF) m_drop++;
         end
      end else begin
         if (br) begin
            e_we = 1'b1;
            e_bub = 1'b1;
            if (!r) begin
               m_wrong = 1'b1;
               m_drop_addr = m_pc;
            end
            m_pc = tgt;
         end else if (r && pw) begin
            e_inst = mem(m_pc);
            e_pc = m_pc + 32'd4;
            e_we = 1'b1;
            m_pc = m_pc + 32'd4;
         end else if (r) begin
            held.push_back('{inst: mem(m_pc), pc4: m_pc + 32'd4});
         end else begin
            e_we = pw;
            e_bub = pw;
         end
      end
      if (e_bub && m_bub != 32'hFFFF_FFFF) m_bub++;
      @(negedge clk);
      o_req = imem_req;
      o_we = ifid_write;
      o_addr = imem_addr;
      o_inst = inst_out;
      o_pc = pc_out;
      chk("imem_req", {31'd0, o_req}, {31'd0, e_req});
      chk("ifid_write", {31'd0, o_we}, {31'd0, e_we});
      chk("inst_out", o_inst, e_inst);
      chk("pc_out", o_pc, e_pc);
      if (rst) chk("imem_addr", o_addr, e_addr);
`ifdef FETCH_STATS_EN
      chk("bubble_count", bubble_count, old_bub);
      chk("drop_count", {16'd0, drop_count}, {16'd0, old_drop});
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst1 = 1'b0;
      pw1 = 1'b1;
      br1 = 1'b0;
      tgt1 = 32'd0;
      rdy1 = 1'b0;
      rdata1 = 32'd0;
      m_pc = RPC0;
      m_wrong = 1'b0;
      m_drop_addr = 32'd0;
      m_bub = 32'd0;
      m_drop = 16'd0;
      @(posedge clk);
      #1;
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      chk("rst_req", {31'd0, o_req}, 32'd0);
      chk("rst_inst", o_inst, NOP0);

      // zero-wait memory
      for (int i = 0; i < 2; i++) begin
         step(1, 1, 0, 0, 1);
         chk("zw_addr", o_addr, 32'(i * 4));
         chk("zw_pc", o_pc, 32'(i * 4 + 4));
         chk("zw_we", {31'd0, o_we}, 32'd1);
      end
      // two-cycle latency
      for (int i = 0; i < 2; i++) begin
         step(1, 1, 0, 0, 0);
         chk("lat_wait_addr", o_addr, 32'(8 + i * 4));
         chk("lat_bub", o_inst, NOP0);
         step(1, 1, 0, 0, 1);
         chk("lat_addr", o_addr, 32'(8 + i * 4));
         chk("lat_pc", o_pc, 32'(12 + i * 4));
      end
      // stall while 0x10 returns
      step(1, 0, 0, 0, 1);
      chk("stall_we", {31'd0, o_we}, 32'd0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      chk("stall_we3", {31'd0, o_we}, 32'd0);
      step(1, 1, 0, 0, 0);
      chk("rel_inst", o_inst, mem(32'h10));
      chk("rel_pc", o_pc, 32'h14);
      step(1, 1, 0, 0, 1);
      chk("no_refetch", o_addr, 32'h14);
      step(1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      // redirect with a request to 0x20 outstanding
      step(1, 1, 1, 32'h100, 0);
      chk("br_addr", o_addr, 32'h20);
      chk("br_bub", o_inst, NOP0);
      step(1, 1, 0, 0, 1);
      chk("drop_addr", o_addr, 32'h20);
      chk("drop_inst", o_inst, NOP0);
      step(1, 1, 0, 0, 0);
      chk("tgt_addr", o_addr, 32'h100);
      // branch while holding, with stall
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 32'h200, 0);
      chk("hbr_we", {31'd0, o_we}, 32'd1);
      chk("hbr_pc", o_pc, 32'd0);
      step(1, 1, 0, 0, 0);
      chk("hbr_addr", o_addr, 32'h200);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] t;
         t = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(11))
                                      : $urandom;
         step($urandom_range(99) != 0, $urandom_range(99) < 75,
              $urandom_range(99) < 10, t, $urandom_range(99) < 60);
      end

      // RESET_PC wrap instance
      rst1 = 1'b0;
      rdy1 = 1'b1;
      rdata1 = 32'h1234_5678;
      @(negedge clk);
      chk("w_rst_req", {31'd0, req1}, 32'd0);
      chk("w_rst_we", {31'd0, we1}, 32'd0);
      @(posedge clk);
      #1;
      rst1 = 1'b1;
      rdata1 = 32'hCAFE_0001;
      @(negedge clk);
      chk("w_addr0", addr1, RPC1);
      chk("w_pc0", pc1, 32'd0);
      chk("w_inst0", inst1, 32'hCAFE_0001);
      @(posedge clk);
      #1;
      rdy1 = 1'b0;
      @(negedge clk);
      chk("w_addr1", addr1, 32'd0);
      chk("w_bub", inst1, 32'd0);
      @(posedge clk);
      #1;
      rst1 = 1'b0;
      rdy1 = 1'b1;
      @(negedge clk);
      chk("w_mid_req", {31'd0, req1}, 32'd0);
      chk("w_mid_pc", pc1, 32'd0);
      @(posedge clk);
      #1;
      rst1 = 1'b1;
      rdy1 = 1'b0;
      @(negedge clk);
      chk("w_re_req", {31'd0, req1}, 32'd1);
      chk("w_re_addr", addr1, RPC1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
